// File: rtl/shift_sequencer_pkg.sv
// shift_sequencer_pkg: shared state encoding and default sizes for the shift sequencer
package shift_sequencer_pkg;
  localparam int WIDTH_DEF = 6;
  localparam int CNT_W_DEF = 3;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/shift_reg_le.sv
// shift_reg_le: WIDTH-bit register with parallel load and left shift, serial_in into LSB
module shift_reg_le #(
  parameter int WIDTH = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q
);
  // load wins over shift; otherwise hold
  always_ff @(posedge clock or posedge reset)
    if (reset) q <= '0;
    else if (load) q <= load_data;
    else if (shift_en) q <= {q[WIDTH-2:0], serial_in};
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: accepts a word and shift count, shifts it out MSB-first, pulses done
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_count,
  input  logic             stall,
  input  logic             serial_in,
  output logic             serial_out,
  output logic [WIDTH-1:0] par_out,
  output logic             busy,
  output logic             done
);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_t state, state_next;
  logic [CNT_W-1:0] cnt, eff_cnt;
  logic load, shift_en;
  logic [WIDTH-1:0] q;
  assign eff_cnt = in_count > MAX_CNT ? MAX_CNT : in_count;
  assign load = state == IDLE && in_valid;
  assign shift_en = state == SHIFT && !stall;
  // state register
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_next;
  // next-state: a zero count skips straight to DONE; last unstalled shift ends SHIFT
  always_comb
    state_next = state == IDLE  ? (in_valid ? (eff_cnt == '0 ? DONE : SHIFT) : IDLE) :
                 state == SHIFT ? (shift_en && cnt == ONE ? DONE : SHIFT) :
                 IDLE;
  // remaining-shift counter, loaded with the clamped count on accept
  always_ff @(posedge clock or posedge reset)
    if (reset) cnt <= '0;
    else if (load) cnt <= eff_cnt;
    else if (shift_en) cnt <= cnt - ONE;
  // outputs decoded from state and the shift register only
  always_comb begin
    in_ready = state == IDLE;
    busy = state != IDLE;
    done = state == DONE;
    serial_out = q[WIDTH-1];
    par_out = q;
  end
  shift_reg_le #(.WIDTH(WIDTH)) u_shift_reg (
    .clock(clock),
    .reset(reset),
    .load(load),
    .shift_en(shift_en),
    .load_data(in_data),
    .serial_in(serial_in),
    .q(q)
  );
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed checks of the shift sequencer against hand-computed values
module tb_shift_sequencer;
  logic clock = 0, reset = 1;
  logic in_valid = 0, in_ready, stall = 0, serial_in = 0, serial_out, busy, done;
  logic [5:0] in_data = '0, par_out;
  logic [2:0] in_count = '0;
  int checks = 0, failures = 0;
  shift_sequencer dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_count(in_count), .stall(stall), .serial_in(serial_in),
    .serial_out(serial_out), .par_out(par_out), .busy(busy), .done(done)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic run_cmd(input string tag, input logic [5:0] d, input logic [2:0] c,
                         input logic s, input logic [5:0] exp_par, input int exp_lat);
    int lat;
    in_data = d; in_count = c; serial_in = s; in_valid = 1;
    tick;
    in_valid = 0;
    lat = 0;
    while (!done && lat < 20) begin
      tick;
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_par"}, par_out, exp_par);
    tick;
    check({tag, "_done_off"}, done, 0);
    check({tag, "_ready_back"}, in_ready, 1);
    check({tag, "_par_hold"}, par_out, exp_par);
  endtask
  initial begin
    logic [5:0] pat;
    tick; tick;
    check("rst_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_par", par_out, 0);
    check("rst_sout", serial_out, 0);
    reset = 0;
    tick;
    stall = 1;
    tick;
    check("idle_stall_ready", in_ready, 1);
    stall = 0;
    pat = 6'b101101;
    in_data = pat; in_count = 6; serial_in = 0; in_valid = 1;
    tick;
    in_valid = 0;
    check("basic_sout0", serial_out, 1);
    check("basic_busy", busy, 1);
    check("basic_ready", in_ready, 0);
    for (int k = 1; k <= 5; k++) begin
      tick;
      check($sformatf("basic_sout%0d", k), serial_out, pat[5-k]);
      check($sformatf("basic_nodone%0d", k), done, 0);
    end
    tick;
    check("basic_done", done, 1);
    check("basic_par", par_out, 6'b000000);
    tick;
    check("basic_done_once", done, 0);
    check("basic_ready_back", in_ready, 1);
    run_cmd("partial", 6'b110011, 3'd2, 1'b1, 6'b001111, 2);
    run_cmd("zero", 6'b010101, 3'd0, 1'b0, 6'b010101, 0);
    run_cmd("clamp", 6'b100000, 3'd7, 1'b1, 6'b111111, 6);
    in_data = 6'b000111; in_count = 3; serial_in = 0; in_valid = 1;
    tick;
    in_valid = 0;
    tick;
    check("stall_shift1", par_out, 6'b001110);
    stall = 1; in_valid = 1; in_data = 6'b101010; in_count = 1;
    tick;
    check("stall_ready", in_ready, 0);
    check("stall_hold1", par_out, 6'b001110);
    tick;
    check("stall_hold2", par_out, 6'b001110);
    check("stall_nodone", done, 0);
    stall = 0; in_valid = 0;
    tick;
    check("stall_shift2", par_out, 6'b011100);
    check("stall_nodone2", done, 0);
    tick;
    check("stall_done", done, 1);
    check("stall_par", par_out, 6'b111000);
    tick;
    check("stall_ready_back", in_ready, 1);
    check("stall_not_queued", par_out, 6'b111000);
    in_data = 6'b111111; in_count = 6; serial_in = 0; in_valid = 1;
    tick;
    in_valid = 0;
    tick; tick;
    #2 reset = 1;
    #1;
    check("mrst_par", par_out, 0);
    check("mrst_sout", serial_out, 0);
    check("mrst_ready", in_ready, 1);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    #1 reset = 0;
    for (int k = 0; k < 7; k++) begin
      tick;
      check($sformatf("mrst_nodone%0d", k), done, 0);
    end
    run_cmd("after_rst", 6'b110011, 3'd2, 1'b1, 6'b001111, 2);
    in_data = 6'b101010; in_count = 1; serial_in = 1; in_valid = 1;
    tick;
    in_data = 6'b000001; in_count = 2;
    tick;
    check("b2b_done1", done, 1);
    check("b2b_par1", par_out, 6'b010101);
    tick;
    check("b2b_idle_ready", in_ready, 1);
    check("b2b_idle_par", par_out, 6'b010101);
    tick;
    in_valid = 0;
    check("b2b_accept2", par_out, 6'b000001);
    check("b2b_busy2", busy, 1);
    tick; tick;
    check("b2b_done2", done, 1);
    check("b2b_par2", par_out, 6'b000111);
    tick;
    check("b2b_ready_end", in_ready, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
